// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C responder blocks
//
// Purpose: receiver state encoding, I2C direction bit value, default codec
// address, and the address-byte match helper.
// Ports: none (package).

package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    ACK_A  = 3'd2,
    SUB    = 3'd3,
    ACK_S  = 3'd4,
    DATA   = 3'd5,
    ACK_D  = 3'd6,
    IGNORE = 3'd7
  } i2c_state_t;

  localparam logic       I2C_WRITE_BIT  = 1'b0;
  localparam logic [6:0] I2C_CODEC_ADDR = 7'h1A;

  // True when an address byte selects this device for a write.
  function automatic logic addr_match(input logic [7:0] addr_byte,
                                      input logic [6:0] dev_addr);
    return (addr_byte[7:1] == dev_addr) && (addr_byte[0] == I2C_WRITE_BIT);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// rtl/i2c_line_sync.sv - SCL/SDA synchroniser with edge and bus-condition flags
//
// Purpose: brings the asynchronous bus lines into the system clock domain and
// derives single-cycle SCL edge and START/STOP flags.
// Ports:
//   i_clk, i_resetn        system clock, asynchronous active-low reset
//   i_scl, i_sda           raw bus lines
//   o_scl_rise/o_scl_fall  one-cycle SCL edge flags
//   o_start/o_stop         one-cycle bus condition flags
//   o_sda_s                synchronised SDA level

module i2c_line_sync (
  input  logic i_clk,
  input  logic i_resetn,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop,
  output logic o_sda_s
);

  logic r_scl_meta, r_scl_sync, r_scl_hist;
  logic r_sda_meta, r_sda_sync, r_sda_hist;

  // Reset to the idle-bus level so leaving reset never creates a false edge.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_scl_meta <= 1'b1;
      r_scl_sync <= 1'b1;
      r_scl_hist <= 1'b1;
      r_sda_meta <= 1'b1;
      r_sda_sync <= 1'b1;
      r_sda_hist <= 1'b1;
    end else begin
      r_scl_meta <= i_scl;
      r_scl_sync <= r_scl_meta;
      r_scl_hist <= r_scl_sync;
      r_sda_meta <= i_sda;
      r_sda_sync <= r_sda_meta;
      r_sda_hist <= r_sda_sync;
    end
  end

  // START/STOP require SCL to be high both before and after the SDA change,
  // so an SDA transition coinciding with an SCL edge is not a bus condition.
  logic w_scl_high;
  assign w_scl_high = r_scl_sync & r_scl_hist;

  assign o_scl_rise = r_scl_sync & ~r_scl_hist;
  assign o_scl_fall = ~r_scl_sync & r_scl_hist;
  assign o_start    = w_scl_high & r_sda_hist & ~r_sda_sync;
  assign o_stop     = w_scl_high & ~r_sda_hist & r_sda_sync;
  assign o_sda_s    = r_sda_sync;

endmodule

// File: rtl/i2c_slave_receiver.sv
// rtl/i2c_slave_receiver.sv - write-only I2C responder with register strobe output
//
// Purpose: accepts address+W, sub-address, data on the I2C bus and presents
// each data byte as a one-cycle register write strobe. Only ever pulls SDA
// low during ACK clocks; never touches SCL.
// Ports:
//   CLOCK     system clock (>= 16x SCL)
//   RESET     asynchronous active-low reset
//   I2C_SCLK  bus clock input
//   I2C_SDAT  bus data, driven only 0 or high-Z
//   REG_ADDR  sub-address of current write
//   REG_DATA  data byte of current write
//   REG_WE    one-cycle write strobe, REG_ADDR/REG_DATA valid with it
//   BUSY      high from address-match ACK until STOP/START/reset
//   ACK_OUT   high while SDA is being pulled low

module i2c_slave_receiver
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = I2C_CODEC_ADDR,
  parameter bit         AUTO_INC   = 1'b1
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       I2C_SCLK,
  inout  wire        I2C_SDAT,
  output logic [7:0] REG_ADDR,
  output logic [7:0] REG_DATA,
  output logic       REG_WE,
  output logic       BUSY,
  output logic       ACK_OUT
);

  logic w_scl_rise, w_scl_fall, w_start, w_stop, w_sda_s;

  i2c_line_sync u_line_sync (
    .i_clk      (CLOCK),
    .i_resetn   (RESET),
    .i_scl      (I2C_SCLK),
    .i_sda      (I2C_SDAT),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop),
    .o_sda_s    (w_sda_s)
  );

  i2c_state_t r_state;
  logic [7:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic       r_byte_done;
  logic       r_first_data;
  logic       r_sda_drive;
  logic [7:0] r_reg_addr;
  logic [7:0] r_reg_data;
  logic       r_reg_we;
  logic       r_busy;

  // Open-drain: the only value ever driven is 0.
  assign I2C_SDAT = r_sda_drive ? 1'b0 : 1'bz;

  assign REG_ADDR = r_reg_addr;
  assign REG_DATA = r_reg_data;
  assign REG_WE   = r_reg_we;
  assign BUSY     = r_busy;
  assign ACK_OUT  = r_sda_drive;

  logic w_shift_state;
  assign w_shift_state = (r_state == ADDR) || (r_state == SUB) || (r_state == DATA);

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_state      <= IDLE;
      r_shift      <= 8'h00;
      r_bit_cnt    <= 3'd0;
      r_byte_done  <= 1'b0;
      r_first_data <= 1'b0;
      r_sda_drive  <= 1'b0;
      r_reg_addr   <= 8'h00;
      r_reg_data   <= 8'h00;
      r_reg_we     <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_reg_we <= 1'b0;
      if (w_start) begin
        r_state     <= ADDR;
        r_bit_cnt   <= 3'd0;
        r_byte_done <= 1'b0;
        r_sda_drive <= 1'b0;
        r_busy      <= 1'b0;
      end else if (w_stop) begin
        r_state     <= IDLE;
        r_bit_cnt   <= 3'd0;
        r_byte_done <= 1'b0;
        r_sda_drive <= 1'b0;
        r_busy      <= 1'b0;
      end else if (w_shift_state) begin
        if (w_scl_rise && !r_byte_done) begin
          // Counter saturates at 7; the done flag marks the eighth bit.
          r_shift <= {r_shift[6:0], w_sda_s};
          if (r_bit_cnt == 3'd7) begin
            r_byte_done <= 1'b1;
          end else begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
        end else if (w_scl_fall && r_byte_done) begin
          // Falling edge closing bit 8: byte is complete, ACK clock starts.
          r_byte_done <= 1'b0;
          r_bit_cnt   <= 3'd0;
          if (r_state == ADDR) begin
            if (addr_match(r_shift, SLAVE_ADDR)) begin
              r_state     <= ACK_A;
              r_sda_drive <= 1'b1;
              r_busy      <= 1'b1;
            end else begin
              r_state <= IGNORE;
            end
          end else if (r_state == SUB) begin
            r_reg_addr  <= r_shift;
            r_state     <= ACK_S;
            r_sda_drive <= 1'b1;
          end else begin
            // Later bytes advance the address so it is already updated
            // in the strobe cycle.
            r_reg_data <= r_shift;
            if (AUTO_INC && !r_first_data) begin
              r_reg_addr <= r_reg_addr + 8'd1;
            end
            r_first_data <= 1'b0;
            r_reg_we     <= 1'b1;
            r_state      <= ACK_D;
            r_sda_drive  <= 1'b1;
          end
        end
      end else begin
        case (r_state)
          ACK_A: begin
            if (w_scl_fall) begin
              r_sda_drive <= 1'b0;
              r_state     <= SUB;
            end
          end
          ACK_S: begin
            if (w_scl_fall) begin
              r_sda_drive  <= 1'b0;
              r_first_data <= 1'b1;
              r_state      <= DATA;
            end
          end
          ACK_D: begin
            if (w_scl_fall) begin
              r_sda_drive <= 1'b0;
              r_state     <= AUTO_INC ? DATA : IGNORE;
            end
          end
          IDLE, IGNORE: begin
            r_sda_drive <= 1'b0;
          end
          default: begin
            r_state     <= IDLE;
            r_sda_drive <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_receiver.sv
// tb/tb_i2c_slave_receiver.sv - scoreboard bench for i2c_slave_receiver

module tb_i2c_slave_receiver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda_low = 1'b0;
  wire        sda0, sda1;

  assign sda0 = m_sda_low ? 1'b0 : 1'bz;
  assign sda1 = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda0);
  pullup (sda1);

  logic [7:0] addr0, data0, addr1, data1;
  logic       we0, busy0, ack_out0, we1, busy1, ack_out1;

  i2c_slave_receiver #(.SLAVE_ADDR(7'h1A), .AUTO_INC(1'b1)) u_dut0 (
    .CLOCK(clk), .RESET(rst_n), .I2C_SCLK(scl), .I2C_SDAT(sda0),
    .REG_ADDR(addr0), .REG_DATA(data0), .REG_WE(we0), .BUSY(busy0), .ACK_OUT(ack_out0)
  );

  i2c_slave_receiver #(.SLAVE_ADDR(7'h1A), .AUTO_INC(1'b0)) u_dut1 (
    .CLOCK(clk), .RESET(rst_n), .I2C_SCLK(scl), .I2C_SDAT(sda1),
    .REG_ADDR(addr1), .REG_DATA(data1), .REG_WE(we1), .BUSY(busy1), .ACK_OUT(ack_out1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n) begin
      if (we0) begin
        if (q0.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL dut0_unexpected_we: got addr %0h data %0h expected no write", addr0, data0);
        end else begin
          logic [15:0] e0;
          e0 = q0.pop_front();
          check("dut0_we_addr", {24'h0, addr0}, {24'h0, e0[15:8]});
          check("dut0_we_data", {24'h0, data0}, {24'h0, e0[7:0]});
        end
      end
      if (we1) begin
        if (q1.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL dut1_unexpected_we: got addr %0h data %0h expected no write", addr1, data1);
        end else begin
          logic [15:0] e1;
          e1 = q1.pop_front();
          check("dut1_we_addr", {24'h0, addr1}, {24'h0, e1[15:8]});
          check("dut1_we_data", {24'h0, data1}, {24'h0, e1[7:0]});
        end
      end
    end
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; wait_clk(3);
    scl = 1'b1;       wait_clk(5);
    m_sda_low = 1'b1; wait_clk(5);
    scl = 1'b0;       wait_clk(3);
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; wait_clk(3);
    scl = 1'b1;       wait_clk(5);
    m_sda_low = 1'b0; wait_clk(8);
  endtask

  task automatic send_bit(input logic b);
    m_sda_low = ~b; wait_clk(4);
    scl = 1'b1;     wait_clk(10);
    scl = 1'b0;     wait_clk(6);
  endtask

  // Sends one byte and checks the ACK clock on both buses.
  task automatic xfer_byte(input logic [7:0] b, input logic exp_a0, input logic exp_a1,
                           input string name);
    logic [7:0] v;
    v = b;
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    m_sda_low = 1'b0; wait_clk(4);
    scl = 1'b1;       wait_clk(5);
    check({name, "_ack0"}, {31'h0, sda0 === 1'b0}, {31'h0, exp_a0});
    check({name, "_ackout0"}, {31'h0, ack_out0}, {31'h0, exp_a0});
    check({name, "_ack1"}, {31'h0, sda1 === 1'b0}, {31'h0, exp_a1});
    wait_clk(5);
    scl = 1'b0;       wait_clk(6);
  endtask

  initial begin
    wait_clk(3);
    check("rst_addr", {24'h0, addr0}, 32'h0);
    check("rst_data", {24'h0, data0}, 32'h0);
    check("rst_we", {31'h0, we0}, 32'h0);
    check("rst_busy", {31'h0, busy0}, 32'h0);
    check("rst_ackout", {31'h0, ack_out0}, 32'h0);
    check("rst_sda", {31'h0, sda0 === 1'b1}, 32'h1);
    rst_n = 1'b1;
    wait_clk(5);

    // Basic write
    q0.push_back(16'h0C5A); q1.push_back(16'h0C5A);
    i2c_start();
    xfer_byte(8'h34, 1, 1, "t1_addr");
    xfer_byte(8'h0C, 1, 1, "t1_sub");
    check("t1_busy_sub", {31'h0, busy0}, 32'h1);
    xfer_byte(8'h5A, 1, 1, "t1_data");
    check("t1_busy_pre_stop", {31'h0, busy0}, 32'h1);
    i2c_stop();
    check("t1_busy_post_stop0", {31'h0, busy0}, 32'h0);
    check("t1_busy_post_stop1", {31'h0, busy1}, 32'h0);

    // Wrong address
    i2c_start();
    xfer_byte(8'h36, 0, 0, "t2_addr");
    check("t2_busy", {31'h0, busy0}, 32'h0);
    xfer_byte(8'h0C, 0, 0, "t2_sub");
    xfer_byte(8'h5A, 0, 0, "t2_data");
    check("t2_busy_end", {31'h0, busy0}, 32'h0);
    i2c_stop();

    // Read bit set
    i2c_start();
    xfer_byte(8'h35, 0, 0, "t3_addr");
    xfer_byte(8'h0C, 0, 0, "t3_sub");
    check("t3_busy", {31'h0, busy0}, 32'h0);
    i2c_stop();

    // Partial data byte, then a full write
    i2c_start();
    xfer_byte(8'h34, 1, 1, "t4_addr");
    xfer_byte(8'h0D, 1, 1, "t4_sub");
    send_bit(1); send_bit(0); send_bit(1); send_bit(0); send_bit(1);
    i2c_stop();
    check("t4_keep_addr", {24'h0, addr0}, 32'h0D);
    check("t4_keep_data", {24'h0, data0}, 32'h5A);
    q0.push_back(16'h10FF); q1.push_back(16'h10FF);
    i2c_start();
    xfer_byte(8'h34, 1, 1, "t4b_addr");
    xfer_byte(8'h10, 1, 1, "t4b_sub");
    xfer_byte(8'hFF, 1, 1, "t4b_data");
    i2c_stop();
    check("t4b_addr_out", {24'h0, addr0}, 32'h10);
    check("t4b_data_out", {24'h0, data0}, 32'hFF);

    // Auto-increment with wrap; dut1 takes only the first data byte
    q0.push_back(16'hFE11); q0.push_back(16'hFF22); q0.push_back(16'h0033);
    q1.push_back(16'hFE11);
    i2c_start();
    xfer_byte(8'h34, 1, 1, "t5_addr");
    xfer_byte(8'hFE, 1, 1, "t5_sub");
    xfer_byte(8'h11, 1, 1, "t5_d0");
    xfer_byte(8'h22, 1, 0, "t5_d1");
    xfer_byte(8'h33, 1, 0, "t5_d2");
    i2c_stop();
    check("t5_wrap_addr", {24'h0, addr0}, 32'h00);
    check("t5_noinc_addr", {24'h0, addr1}, 32'hFE);

    // Reset during the sub-address ACK
    i2c_start();
    xfer_byte(8'h34, 1, 1, "t6_addr");
    for (int i = 7; i >= 0; i--) send_bit(i[0] ^ i[1]);
    m_sda_low = 1'b0; wait_clk(4);
    scl = 1'b1;       wait_clk(3);
    check("t6_pre_ackout", {31'h0, ack_out0}, 32'h1);
    check("t6_pre_sda", {31'h0, sda0 === 1'b0}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_sda0", {31'h0, sda0 === 1'b1}, 32'h1);
    check("t6_rst_sda1", {31'h0, sda1 === 1'b1}, 32'h1);
    check("t6_rst_ackout", {31'h0, ack_out0}, 32'h0);
    check("t6_rst_addr", {24'h0, addr0}, 32'h0);
    check("t6_rst_data", {24'h0, data0}, 32'h0);
    check("t6_rst_busy", {31'h0, busy0}, 32'h0);
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(2);
    scl = 1'b0; wait_clk(6);
    i2c_stop();
    q0.push_back(16'h20A5); q1.push_back(16'h20A5);
    i2c_start();
    xfer_byte(8'h34, 1, 1, "t6b_addr");
    xfer_byte(8'h20, 1, 1, "t6b_sub");
    xfer_byte(8'hA5, 1, 1, "t6b_data");
    i2c_stop();

    wait_clk(5);
    check("q0_drained", q0.size(), 32'h0);
    check("q1_drained", q1.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
